// File: rtl/alu_move_sched_pkg.sv
// Shared ALU opcode values, direction encoding and scheduler state type.
// The CPU decode logic uses the same opcode values.
package alu_move_sched_pkg;

    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_OR  = 5'b00011;
    localparam logic [4:0] OP_SUR = 5'b00110;
    localparam logic [4:0] OP_SUL = 5'b00111;
    localparam logic [4:0] OP_SDR = 5'b10110;
    localparam logic [4:0] OP_SDL = 5'b10111;

    localparam logic [1:0] DIR_UR = 2'd0;
    localparam logic [1:0] DIR_UL = 2'd1;
    localparam logic [1:0] DIR_DR = 2'd2;
    localparam logic [1:0] DIR_DL = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Diagonal shift opcode for a direction.
    function automatic logic [4:0] shift_op(input logic [1:0] dir);
        case (dir)
            DIR_UR:  return OP_SUR;
            DIR_UL:  return OP_SUL;
            DIR_DR:  return OP_SDR;
            default: return OP_SDL;
        endcase
    endfunction

endpackage

// File: rtl/alu_move_sched.sv
// Borrows idle cycles of the shared CPU ALU to build checkers single-step
// move masks. Each direction takes three ALU ops: shift, AND empty, OR acc.
// Per-direction results are staged and only published when a scan completes,
// so an aborted scan leaves the previous results visible.
module alu_move_sched
    import alu_move_sched_pkg::*;
#(
    parameter logic MEN_UP = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] men,
    input  logic [31:0] kings,
    input  logic [31:0] empty,
    input  logic        cpu_alu_req,
    input  logic [31:0] alu_result,
    output logic        alu_sel,
    output logic [31:0] alu_opA,
    output logic [31:0] alu_opB,
    output logic [4:0]  alu_opcode,
    output logic        busy,
    output logic        done,
    output logic [31:0] mask_ur,
    output logic [31:0] mask_ul,
    output logic [31:0] mask_dr,
    output logic [31:0] mask_dl,
    output logic [31:0] mask_all,
    output logic        any_move
);

    state_t            state_q, state_d;
    logic [1:0]        dir_q, dir_d;
    logic [1:0]        step_q, step_d;
    logic [31:0]       men_q, men_d, kings_q, kings_d, empty_q, empty_d;
    logic [31:0]       tmp_q, tmp_d, acc_q, acc_d;
    logic [3:0][31:0]  stg_q, stg_d;
    logic [3:0][31:0]  pub_q, pub_d;
    logic [31:0]       all_q, all_d;
    logic              any_q, any_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              men_dir;

    // The CPU always wins the ALU; we only issue in RUN on idle cycles.
    assign alu_sel = (state_q == ST_RUN) & ~cpu_alu_req;

    // Men move only in their own two directions; kings in all four.
    assign men_dir = MEN_UP ? ~dir_q[1] : dir_q[1];

    // Present the pending op; held while stalled, zero outside RUN.
    always_comb begin
        alu_opcode = 5'd0;
        alu_opA    = 32'd0;
        alu_opB    = 32'd0;
        if (state_q == ST_RUN) begin
            case (step_q)
                2'd0: begin
                    alu_opcode = shift_op(dir_q);
                    alu_opA    = men_dir ? (men_q | kings_q) : kings_q;
                end
                2'd1: begin
                    alu_opcode = OP_AND;
                    alu_opA    = tmp_q;
                    alu_opB    = empty_q;
                end
                default: begin
                    alu_opcode = OP_OR;
                    alu_opA    = acc_q;
                    alu_opB    = tmp_q;
                end
            endcase
        end
    end

    // Scan sequencing, result capture on granted cycles, publish at completion.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        step_d  = step_q;
        men_d   = men_q;
        kings_d = kings_q;
        empty_d = empty_q;
        tmp_d   = tmp_q;
        acc_d   = acc_q;
        stg_d   = stg_q;
        pub_d   = pub_q;
        all_d   = all_q;
        any_d   = any_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    men_d   = men;
                    kings_d = kings;
                    empty_d = empty;
                    tmp_d   = 32'd0;
                    acc_d   = 32'd0;
                    dir_d   = DIR_UR;
                    step_d  = 2'd0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (alu_sel) begin
                    case (step_q)
                        2'd0: begin
                            tmp_d  = alu_result;
                            step_d = 2'd1;
                        end
                        2'd1: begin
                            tmp_d        = alu_result;
                            stg_d[dir_q] = alu_result;
                            step_d       = 2'd2;
                        end
                        default: begin
                            acc_d  = alu_result;
                            step_d = 2'd0;
                            if (dir_q == DIR_DL) begin
                                pub_d   = stg_q;
                                all_d   = alu_result;
                                any_d   = |alu_result;
                                done_d  = 1'b1;
                                busy_d  = 1'b0;
                                state_d = ST_DONE;
                            end else begin
                                dir_d = dir_q + 2'd1;
                            end
                        end
                    endcase
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            dir_q   <= 2'd0;
            step_q  <= 2'd0;
            men_q   <= 32'd0;
            kings_q <= 32'd0;
            empty_q <= 32'd0;
            tmp_q   <= 32'd0;
            acc_q   <= 32'd0;
            stg_q   <= '0;
            pub_q   <= '0;
            all_q   <= 32'd0;
            any_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            men_q   <= men_d;
            kings_q <= kings_d;
            empty_q <= empty_d;
            tmp_q   <= tmp_d;
            acc_q   <= acc_d;
            stg_q   <= stg_d;
            pub_q   <= pub_d;
            all_q   <= all_d;
            any_q   <= any_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign mask_ur  = pub_q[DIR_UR];
    assign mask_ul  = pub_q[DIR_UL];
    assign mask_dr  = pub_q[DIR_DR];
    assign mask_dl  = pub_q[DIR_DL];
    assign mask_all = all_q;
    assign any_move = any_q;

endmodule

// File: tb/tb_alu_move_sched.sv
// Bench for alu_move_sched: a small ALU model closes the loop, and a
// scan-level model (whole-board masks computed at start, op counter) predicts
// every output each cycle. Directed scans pin the model with literal values.
module tb_alu_move_sched;

    localparam logic [4:0] T_AND = 5'b00010;
    localparam logic [4:0] T_OR  = 5'b00011;
    localparam logic [4:0] T_SUR = 5'b00110;
    localparam logic [4:0] T_SUL = 5'b00111;
    localparam logic [4:0] T_SDR = 5'b10110;
    localparam logic [4:0] T_SDL = 5'b10111;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0, abort = 1'b0, cpu_alu_req = 1'b0;
    logic [31:0] men = '0, kings = '0, empty = '0, alu_result;
    logic        alu_sel, busy, done, any_move;
    logic [31:0] alu_opA, alu_opB, mask_ur, mask_ul, mask_dr, mask_dl, mask_all;
    logic [4:0]  alu_opcode;
    logic [31:0] cpu_a = '0, cpu_b = '0;
    logic [4:0]  cpu_op = '0;

    always #5 clock = ~clock;

    alu_move_sched #(.MEN_UP(1'b1)) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .men(men), .kings(kings), .empty(empty), .cpu_alu_req(cpu_alu_req),
        .alu_result(alu_result), .alu_sel(alu_sel), .alu_opA(alu_opA),
        .alu_opB(alu_opB), .alu_opcode(alu_opcode), .busy(busy), .done(done),
        .mask_ur(mask_ur), .mask_ul(mask_ul), .mask_dr(mask_dr), .mask_dl(mask_dl),
        .mask_all(mask_all), .any_move(any_move)
    );

    function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            T_AND:   return a & b;
            T_OR:    return a | b;
            T_SUR:   return a << 4;
            T_SUL:   return a << 5;
            T_SDR:   return a >> 4;
            T_SDL:   return a >> 5;
            default: return a + b;
        endcase
    endfunction

    // Shared-ALU mux and ALU as they sit at CPU top.
    always_comb alu_result = alu_sel ? alu_fn(alu_opcode, alu_opA, alu_opB)
                                     : alu_fn(cpu_op, cpu_a, cpu_b);

    function automatic logic [4:0] shop(input int d);
        case (d)
            0: return T_SUR;
            1: return T_SUL;
            2: return T_SDR;
            default: return T_SDL;
        endcase
    endfunction

    int n_chk = 0, n_err = 0;
    int cyc = 0, t0 = 0, s_cyc = 0;
    logic s_busy, s_done;
    int done_cnt = 0;
    logic [31:0] opa_c1;
    logic [4:0] trace[$];
    logic rec = 1'b0;
    int stall_lo = -1, stall_hi = -1;
    logic rnd_req = 1'b0;

    // Scan-level model
    logic m_busy, m_done;
    int m_k;
    logic [31:0] m_src[4], m_sh[4], m_mask[4], m_pub[4], m_empty, m_all;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] prefix(input int d);
        logic [31:0] r = '0;
        for (int i = 0; i < d; i++) r |= m_mask[i];
        return r;
    endfunction

    task automatic model_clear();
        m_busy = 0; m_done = 0; m_k = 0; m_empty = '0; m_all = '0;
        for (int i = 0; i < 4; i++) begin
            m_src[i] = '0; m_sh[i] = '0; m_mask[i] = '0; m_pub[i] = '0;
        end
    endtask

    task automatic model_step();
        if (!reset) model_clear();
        else if (m_done) m_done = 0;
        else if (!m_busy) begin
            if (start && !abort) begin
                for (int d = 0; d < 4; d++) begin
                    m_src[d]  = (d < 2) ? (men | kings) : kings;
                    m_sh[d]   = alu_fn(shop(d), m_src[d], 32'd0);
                    m_mask[d] = m_sh[d] & empty;
                end
                m_empty = empty; m_busy = 1; m_k = 0;
            end
        end else if (abort) m_busy = 0;
        else if (!cpu_alu_req) begin
            if (m_k == 11) begin
                m_busy = 0; m_done = 1; m_all = prefix(4);
                for (int i = 0; i < 4; i++) m_pub[i] = m_mask[i];
            end else m_k++;
        end
    endtask

    task automatic compare();
        logic [4:0] eop; logic [31:0] ea, eb; int d, s;
        eop = '0; ea = '0; eb = '0;
        if (m_busy) begin
            d = m_k / 3; s = m_k % 3;
            if (s == 0) begin eop = shop(d); ea = m_src[d]; end
            else if (s == 1) begin eop = T_AND; ea = m_sh[d]; eb = m_empty; end
            else begin eop = T_OR; ea = prefix(d); eb = m_mask[d]; end
        end
        cmp("alu_sel", alu_sel, m_busy & ~cpu_alu_req);
        cmp("alu_opcode", alu_opcode, eop);
        cmp("alu_opA", alu_opA, ea);
        cmp("alu_opB", alu_opB, eb);
        cmp("busy", busy, m_busy);
        cmp("done", done, m_done);
        cmp("mask_ur", mask_ur, m_pub[0]);
        cmp("mask_ul", mask_ul, m_pub[1]);
        cmp("mask_dr", mask_dr, m_pub[2]);
        cmp("mask_dl", mask_dl, m_pub[3]);
        cmp("mask_all", mask_all, m_all);
        cmp("any_move", any_move, m_all != 0);
        s_cyc = cyc; s_busy = busy; s_done = done;
        if (done) done_cnt++;
        if (rec && alu_sel) trace.push_back(alu_opcode);
        if (cyc - t0 == 1) opa_c1 = alu_opA;
    endtask

    task automatic step();
        cpu_a = $urandom; cpu_b = $urandom; cpu_op = 5'($urandom);
        if (rnd_req) cpu_alu_req = ($urandom_range(0, 3) == 0);
        else cpu_alu_req = (cyc - t0 >= stall_lo) && (cyc - t0 <= stall_hi);
        @(negedge clock);
        compare();
        model_step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic begin_scan(input logic [31:0] mn, input logic [31:0] kg, input logic [31:0] em);
        men = mn; kings = kg; empty = em; start = 1; t0 = cyc;
        step();
        start = 0;
    endtask

    task automatic wait_done(output int dcyc);
        dcyc = -1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (s_done) begin dcyc = s_cyc - t0; break; end
        end
        if (dcyc < 0) begin
            n_chk++; n_err++;
            $display("FAIL wait_done: no done pulse within 100 cycles");
        end
    endtask

    task automatic check_single_man(input string tag);
        cmp({tag, "_ur"}, mask_ur, 32'h0000_0200);
        cmp({tag, "_ul"}, mask_ul, 32'h0000_0400);
        cmp({tag, "_dr"}, mask_dr, 32'h0);
        cmp({tag, "_dl"}, mask_dl, 32'h0);
        cmp({tag, "_all"}, mask_all, 32'h0000_0600);
        cmp({tag, "_any"}, any_move, 32'h1);
    endtask

    initial begin
        int dc;
        logic [4:0] exp_tr[12];
        exp_tr = '{5'b00110, 5'b00010, 5'b00011, 5'b00111, 5'b00010, 5'b00011,
                   5'b10110, 5'b00010, 5'b00011, 5'b10111, 5'b00010, 5'b00011};
        model_clear();
        #1;
        step(); step();
        cmp("reset_busy", busy, 32'h0);
        cmp("reset_all", mask_all, 32'h0);
        reset = 1;
        step();

        // Empty board: opcode trace and exact latency.
        rec = 1; trace.delete();
        begin_scan(32'h0, 32'h0, 32'hFFFF_FFFF);
        wait_done(dc);
        rec = 0;
        cmp("t1_done_cycle", dc, 13);
        cmp("t1_trace_len", trace.size(), 12);
        for (int i = 0; i < 12 && i < trace.size(); i++) cmp("t1_trace", trace[i], exp_tr[i]);
        cmp("t1_any", any_move, 32'h0);
        step(); step();

        // Single man at bit 5.
        begin_scan(32'h20, 32'h0, 32'hFFFF_FFFF);
        wait_done(dc);
        cmp("t2_done_cycle", dc, 13);
        cmp("t2_opa_c1", opa_c1, 32'h20);
        check_single_man("t2");
        step(); step();

        // Same with CPU holding the ALU in cycles 3-5.
        stall_lo = 3; stall_hi = 5;
        begin_scan(32'h20, 32'h0, 32'hFFFF_FFFF);
        wait_done(dc);
        stall_lo = -1; stall_hi = -1;
        cmp("t3_done_cycle", dc, 16);
        check_single_man("t3");
        step(); step();

        // Abort in cycle 6: no done, previous masks stay.
        done_cnt = 0;
        begin_scan(32'h0001_0000, 32'h0100_0000, 32'hFFFF_FFFF);
        for (int i = 1; i < 6; i++) step();
        abort = 1; step(); abort = 0;
        step();
        cmp("t4_busy_c7", s_busy, 32'h0);
        for (int i = 0; i < 20; i++) step();
        cmp("t4_no_done", done_cnt, 0);
        check_single_man("t4");

        // Abort together with start in IDLE: start ignored.
        men = 32'h1; start = 1; abort = 1; step(); start = 0; abort = 0;
        step();
        cmp("t5_abort_wins", s_busy, 32'h0);

        // Start held through cycle 13: exactly one done.
        done_cnt = 0;
        men = 32'h40; kings = 32'h0; empty = 32'hFFFF_FFFF; start = 1; t0 = cyc;
        for (int i = 0; i < 14; i++) step();
        start = 0;
        for (int i = 0; i < 30; i++) step();
        cmp("t6_single_done", done_cnt, 1);

        // Asynchronous reset in cycle 4, then a fresh scan.
        begin_scan(32'h20, 32'h0, 32'hFFFF_FFFF);
        for (int i = 1; i < 4; i++) step();
        #1; reset = 0; #1;
        model_clear();
        cmp("t7_busy", busy, 32'h0);
        cmp("t7_done", done, 32'h0);
        cmp("t7_all", mask_all, 32'h0);
        cmp("t7_ur", mask_ur, 32'h0);
        cmp("t7_any", any_move, 32'h0);
        cmp("t7_sel", alu_sel, 32'h0);
        step();
        reset = 1;
        step();
        begin_scan(32'h20, 32'h0, 32'hFFFF_FFFF);
        wait_done(dc);
        cmp("t7_done_cycle", dc, 13);
        check_single_man("t7");

        // Randomized traffic against the model.
        rnd_req = 1;
        for (int it = 0; it < 40; it++) begin
            men   = $urandom & $urandom;
            kings = $urandom & $urandom & $urandom;
            empty = ~(men | kings) & ($urandom | $urandom);
            for (int c = 0; c < 30; c++) begin
                start = ($urandom_range(0, 3) == 0);
                abort = ($urandom_range(0, 40) == 0);
                step();
            end
        end
        start = 0; abort = 0; rnd_req = 0;
        for (int i = 0; i < 30; i++) step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
